// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: mode encoding, forward codes
// and the scoreboard entry layout with its match helper.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALL   = 2'd1,
        MEMWAIT = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EXE = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    typedef struct packed {
        logic [4:0] wr;
        logic       wreg;
        logic       ld;
    } sb_entry_t;

    // $0 is hardwired to zero, so a write to it never creates a dependency.
    function automatic logic sb_match(input sb_entry_t e, input logic use_src,
                                      input logic [4:0] src);
        return use_src & e.wreg & (e.wr == src) & (e.wr != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shadow copy of the EXE/MEM destination fields plus operand match/forward logic.
// HAZ_FWD_EN selects forwarding; without it every in-flight match stalls.
module hazard_scoreboard
    import pipeline_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_wreg,
    input  logic       id_ld,
    input  logic [4:0] id_wr,
    input  logic       id_exe_en,
    input  logic       id_exe_flush,
    input  logic       exe_mem_en,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       hazard
);

    sb_entry_t exe_r;
    sb_entry_t mem_r;
    logic exe_a_s, exe_b_s, mem_a_s, mem_b_s;

    // Shadow registers follow the pipeline register enables; a flush inserts a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_r <= '0;
            mem_r <= '0;
        end else begin
            if (id_exe_en) begin
                exe_r <= id_exe_flush ? sb_entry_t'(7'd0) : sb_entry_t'({id_wr, id_wreg, id_ld});
            end
            if (exe_mem_en) begin
                mem_r <= exe_r;
            end
        end
    end

    assign exe_a_s = sb_match(exe_r, id_use_rs, id_rs);
    assign exe_b_s = sb_match(exe_r, id_use_rt, id_rt);
    assign mem_a_s = sb_match(mem_r, id_use_rs, id_rs);
    assign mem_b_s = sb_match(mem_r, id_use_rt, id_rt);

`ifdef HAZ_FWD_EN
    // EXE wins over MEM; a load in EXE cannot forward yet and becomes a hazard.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (exe_a_s && !exe_r.ld) begin
            fwd_a = FWD_EXE;
        end else if (mem_a_s) begin
            fwd_a = FWD_MEM;
        end else begin
            fwd_a = FWD_RF;
        end
        if (exe_b_s && !exe_r.ld) begin
            fwd_b = FWD_EXE;
        end else if (mem_b_s) begin
            fwd_b = FWD_MEM;
        end else begin
            fwd_b = FWD_RF;
        end
        hazard = (exe_a_s | exe_b_s) & exe_r.ld;
    end
`else
    // No bypass network: wait until the producer reaches WB.
    always_comb begin
        fwd_a  = FWD_RF;
        fwd_b  = FWD_RF;
        hazard = exe_a_s | exe_b_s | mem_a_s | mem_b_s;
    end
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard/sequencing controller: stage enables, flushes, forwarding and
// stall counting. Build option HAZ_FWD_EN enables operand forwarding.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_Use_rs,
    input  logic             ID_Use_rt,
    input  logic             ID_Wreg,
    input  logic             ID_Reg2reg,
    input  logic [4:0]       ID_write_reg,
    input  logic             EXE_Taken,
    input  logic             Mem_req,
    input  logic             Mem_ready,
    output logic             PC_en,
    output logic             IF_ID_en,
    output logic             ID_EXE_en,
    output logic             EXE_MEM_en,
    output logic             MEM_WB_en,
    output logic             IF_ID_flush,
    output logic             ID_EXE_flush,
    output logic [1:0]       Fwd_A,
    output logic [1:0]       Fwd_B,
    output logic [CNT_W-1:0] Stall_cnt,
    output logic [1:0]       Ctrl_state
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ctrl_state_t      mode_s;
    logic             hazard_s;
    logic [CNT_W-1:0] cnt_r;

    hazard_scoreboard u_sb (
        .clk          (Clk),
        .rst_n        (Clrn),
        .id_rs        (ID_rs),
        .id_rt        (ID_rt),
        .id_use_rs    (ID_Use_rs),
        .id_use_rt    (ID_Use_rt),
        .id_wreg      (ID_Wreg),
        .id_ld        (ID_Reg2reg),
        .id_wr        (ID_write_reg),
        .id_exe_en    (ID_EXE_en),
        .id_exe_flush (ID_EXE_flush),
        .exe_mem_en   (EXE_MEM_en),
        .fwd_a        (Fwd_A),
        .fwd_b        (Fwd_B),
        .hazard       (hazard_s)
    );

    // Mode selection and stage controls; while Clrn is low everything reads as RUN.
    always_comb begin
        mode_s       = RUN;
        PC_en        = 1'b1;
        IF_ID_en     = 1'b1;
        ID_EXE_en    = 1'b1;
        EXE_MEM_en   = 1'b1;
        MEM_WB_en    = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EXE_flush = 1'b0;
        if (!Clrn) begin
            mode_s = RUN;
        end else if (Mem_req && !Mem_ready) begin
            // A pending branch stays frozen in EXE and is taken once the wait ends.
            mode_s     = MEMWAIT;
            PC_en      = 1'b0;
            IF_ID_en   = 1'b0;
            ID_EXE_en  = 1'b0;
            EXE_MEM_en = 1'b0;
            MEM_WB_en  = 1'b0;
        end else if (EXE_Taken) begin
            mode_s       = RUN;
            IF_ID_flush  = 1'b1;
            ID_EXE_flush = 1'b1;
        end else if (hazard_s) begin
            mode_s       = STALL;
            PC_en        = 1'b0;
            IF_ID_en     = 1'b0;
            ID_EXE_flush = 1'b1;
        end else begin
            mode_s = RUN;
        end
    end

    assign Ctrl_state = mode_s;
    assign Stall_cnt  = cnt_r;

    // Saturating count of STALL and MEMWAIT cycles.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            cnt_r <= '0;
        end else if ((mode_s != RUN) && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; expectations follow HAZ_FWD_EN.
module tb_pipeline_hazard_ctrl;

    logic       Clk = 1'b0;
    logic       Clrn;
    logic [4:0] ID_rs, ID_rt, ID_write_reg;
    logic       ID_Use_rs, ID_Use_rt, ID_Wreg, ID_Reg2reg;
    logic       EXE_Taken, Mem_req, Mem_ready;
    logic       PC_en, IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en;
    logic       IF_ID_flush, ID_EXE_flush;
    logic [1:0] Fwd_A, Fwd_B, Ctrl_state;
    logic [3:0] Stall_cnt;

    int total = 0;
    int bad = 0;
    logic [3:0] exp_cnt = 4'd0;

    wire [4:0] en_v = {PC_en, IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en};
    wire [1:0] fl_v = {IF_ID_flush, ID_EXE_flush};

    pipeline_hazard_ctrl #(.CNT_W(4)) dut (
        .Clk(Clk), .Clrn(Clrn), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_Use_rs(ID_Use_rs), .ID_Use_rt(ID_Use_rt), .ID_Wreg(ID_Wreg),
        .ID_Reg2reg(ID_Reg2reg), .ID_write_reg(ID_write_reg),
        .EXE_Taken(EXE_Taken), .Mem_req(Mem_req), .Mem_ready(Mem_ready),
        .PC_en(PC_en), .IF_ID_en(IF_ID_en), .ID_EXE_en(ID_EXE_en),
        .EXE_MEM_en(EXE_MEM_en), .MEM_WB_en(MEM_WB_en),
        .IF_ID_flush(IF_ID_flush), .ID_EXE_flush(ID_EXE_flush),
        .Fwd_A(Fwd_A), .Fwd_B(Fwd_B), .Stall_cnt(Stall_cnt), .Ctrl_state(Ctrl_state)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic cnt_step();
        if (exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic wreg, input logic ld, input logic [4:0] wr);
        ID_rs = rs; ID_rt = rt; ID_Use_rs = urs; ID_Use_rt = urt;
        ID_Wreg = wreg; ID_Reg2reg = ld; ID_write_reg = wr;
    endtask

    task automatic drain();
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        EXE_Taken = 1'b0; Mem_req = 1'b0; Mem_ready = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset();
        Clrn = 1'b0; Mem_req = 1'b1; Mem_ready = 1'b0; EXE_Taken = 1'b1;
        set_id(5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd1);
        #2;
        total++; if (en_v !== 5'b11111) begin bad++; $display("FAIL reset_en got=%b exp=11111", en_v); end
        total++; if (fl_v !== 2'b00) begin bad++; $display("FAIL reset_flush got=%b exp=00", fl_v); end
        total++; if ({Fwd_A, Fwd_B} !== 4'b0000) begin bad++; $display("FAIL reset_fwd got=%b exp=0000", {Fwd_A, Fwd_B}); end
        total++; if (Stall_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", Stall_cnt); end
        total++; if (Ctrl_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", Ctrl_state); end
        #1;
        Mem_req = 1'b0; EXE_Taken = 1'b0;
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        Clrn = 1'b1;
        tick();
    endtask

    task automatic test_fwd_exe();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);   // add $3,$1,$2
        tick();
        set_id(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);   // sub $4,$3,$5
        #2;
`ifdef HAZ_FWD_EN
        total++; if ({Fwd_A, Fwd_B} !== 4'b0100) begin bad++; $display("FAIL fwd_exe_fwd got=%b exp=0100", {Fwd_A, Fwd_B}); end
        total++; if (en_v !== 5'b11111 || Ctrl_state !== 2'd0) begin bad++; $display("FAIL fwd_exe_run en=%b st=%0d exp=11111/0", en_v, Ctrl_state); end
        tick();
`else
        total++; if (Ctrl_state !== 2'd1 || en_v !== 5'b00111) begin bad++; $display("FAIL nofwd_exe_stall1 st=%0d en=%b exp=1/00111", Ctrl_state, en_v); end
        tick(); cnt_step(); #2;
        total++; if (Ctrl_state !== 2'd1 || fl_v !== 2'b01) begin bad++; $display("FAIL nofwd_exe_stall2 st=%0d fl=%b exp=1/01", Ctrl_state, fl_v); end
        tick(); cnt_step(); #2;
        total++; if (Ctrl_state !== 2'd0 || en_v !== 5'b11111) begin bad++; $display("FAIL nofwd_exe_resume st=%0d en=%b exp=0/11111", Ctrl_state, en_v); end
        tick();
`endif
        total++; if (Stall_cnt !== exp_cnt) begin bad++; $display("FAIL fwd_exe_cnt got=%0d exp=%0d", Stall_cnt, exp_cnt); end
        drain();
    endtask

    task automatic test_load_use();
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);   // lw $3,0($1)
        tick();
        set_id(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);   // add $4,$3,$3
        #2;
        total++; if (en_v !== 5'b00111 || fl_v !== 2'b01) begin bad++; $display("FAIL lu_stall en=%b fl=%b exp=00111/01", en_v, fl_v); end
        total++; if (Ctrl_state !== 2'd1) begin bad++; $display("FAIL lu_state got=%0d exp=1", Ctrl_state); end
        tick(); cnt_step(); #2;
`ifdef HAZ_FWD_EN
        total++; if ({Fwd_A, Fwd_B} !== 4'b1010 || Ctrl_state !== 2'd0) begin bad++; $display("FAIL lu_fwd_mem fwd=%b st=%0d exp=1010/0", {Fwd_A, Fwd_B}, Ctrl_state); end
`else
        total++; if (Ctrl_state !== 2'd1 || {Fwd_A, Fwd_B} !== 4'b0000) begin bad++; $display("FAIL lu_nofwd_stall2 st=%0d fwd=%b exp=1/0000", Ctrl_state, {Fwd_A, Fwd_B}); end
        tick(); cnt_step(); #2;
        total++; if (Ctrl_state !== 2'd0) begin bad++; $display("FAIL lu_nofwd_resume st=%0d exp=0", Ctrl_state); end
`endif
        total++; if (Stall_cnt !== exp_cnt) begin bad++; $display("FAIL lu_cnt got=%0d exp=%0d", Stall_cnt, exp_cnt); end
        drain();
    endtask

    task automatic test_zero_reg();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0);   // producer of $0
        tick();
        set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6);
        #2;
        total++; if ({Fwd_A, Fwd_B} !== 4'b0000) begin bad++; $display("FAIL zero_fwd got=%b exp=0000", {Fwd_A, Fwd_B}); end
        total++; if (en_v !== 5'b11111 || Ctrl_state !== 2'd0) begin bad++; $display("FAIL zero_nostall en=%b st=%0d exp=11111/0", en_v, Ctrl_state); end
        drain();
    endtask

    task automatic test_taken_hazard();
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7);   // lw $7
        tick();
        set_id(5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8);
        EXE_Taken = 1'b1;
        #2;
        total++; if (en_v !== 5'b11111 || fl_v !== 2'b11) begin bad++; $display("FAIL taken_ctrl en=%b fl=%b exp=11111/11", en_v, fl_v); end
        total++; if (Ctrl_state !== 2'd0) begin bad++; $display("FAIL taken_state got=%0d exp=0", Ctrl_state); end
        tick();
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        EXE_Taken = 1'b0;
        #2;
        total++; if (Stall_cnt !== exp_cnt) begin bad++; $display("FAIL taken_cnt got=%0d exp=%0d", Stall_cnt, exp_cnt); end
        drain();
    endtask

    task automatic test_mem_wait();
        Mem_req = 1'b1; Mem_ready = 1'b0; EXE_Taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            total++; if (en_v !== 5'b00000 || fl_v !== 2'b00 || Ctrl_state !== 2'd2) begin
                bad++; $display("FAIL wait_cyc%0d en=%b fl=%b st=%0d exp=00000/00/2", i, en_v, fl_v, Ctrl_state);
            end
            tick(); cnt_step();
        end
        Mem_ready = 1'b1;
        #2;
        total++; if (en_v !== 5'b11111 || fl_v !== 2'b11) begin bad++; $display("FAIL wait_done en=%b fl=%b exp=11111/11", en_v, fl_v); end
        total++; if (Stall_cnt !== exp_cnt) begin bad++; $display("FAIL wait_cnt got=%0d exp=%0d", Stall_cnt, exp_cnt); end
        drain();
    endtask

    task automatic test_reset_in_wait();
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9);   // lw $9
        tick();
        set_id(5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 5'd10);
        Mem_req = 1'b1; Mem_ready = 1'b0;
        tick(); cnt_step();
        Clrn = 1'b0;
        #1;
        exp_cnt = 4'd0;
        total++; if (en_v !== 5'b11111 || fl_v !== 2'b00 || Ctrl_state !== 2'd0) begin
            bad++; $display("FAIL rst_wait_ctrl en=%b fl=%b st=%0d exp=11111/00/0", en_v, fl_v, Ctrl_state);
        end
        total++; if (Stall_cnt !== 4'd0 || {Fwd_A, Fwd_B} !== 4'b0000) begin bad++; $display("FAIL rst_wait_cnt cnt=%0d fwd=%b exp=0/0000", Stall_cnt, {Fwd_A, Fwd_B}); end
        Mem_req = 1'b0;
        Clrn = 1'b1;
        #1;
        total++; if (PC_en !== 1'b1 || Ctrl_state !== 2'd0) begin bad++; $display("FAIL rst_sb_clear pc_en=%b st=%0d exp=1/0", PC_en, Ctrl_state); end
        drain();
    endtask

    task automatic test_saturation();
        Mem_req = 1'b1; Mem_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(); cnt_step();
        end
        #2;
        total++; if (Stall_cnt !== 4'd15 || Stall_cnt !== exp_cnt) begin bad++; $display("FAIL sat_cnt got=%0d exp=15", Stall_cnt); end
        Mem_ready = 1'b1;
        #1;
        total++; if (en_v !== 5'b11111) begin bad++; $display("FAIL sat_resume en=%b exp=11111", en_v); end
        drain();
    endtask

    initial begin
        test_reset();
        test_fwd_exe();
        test_load_use();
        test_zero_reg();
        test_taken_hazard();
        test_mem_wait();
        test_reset_in_wait();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
